// File: rtl/confusion_pkg.sv
// Shared types and constants for the AES byte-substitution (confusion) stage:
// byte/state matrix types, forward and inverse S-box tables, FSM states.
package confusion_pkg;

  typedef logic [7:0] byte_t;
  typedef byte_t [3:0][3:0] state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    HOLD = 2'd2
  } state_e;

  // Entry 0 sits in the most significant byte, so the literals read in table order.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

endpackage

// File: rtl/confusion_sbox.sv
// Combinational AES S-box lookup for one byte; inverse selects the inverse table.
module sbox
  import confusion_pkg::*;
(
  input  logic [7:0] in_byte,
  input  logic       inverse,
  output logic [7:0] out_byte
);

  assign out_byte = inverse ? INV_SBOX[in_byte] : SBOX[in_byte];

endmodule

// File: rtl/confusion.sv
// Iterative SubBytes stage: captures a state matrix, substitutes BYTES_PER_CYCLE
// bytes per cycle in place, then holds the result until downstream takes it.
module confusion
  import confusion_pkg::*;
#(
  parameter int BYTES_PER_CYCLE = 1
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   in_valid,
  output logic   in_ready,
  input  logic   inverse,
  input  state_t confusion_in,
  output logic   out_valid,
  input  logic   out_ready,
  output state_t confusion_out,
  output state_e dbg_state
);

  if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 ||
        BYTES_PER_CYCLE == 4 || BYTES_PER_CYCLE == 16)) begin : g_bad_param
    $error("confusion: BYTES_PER_CYCLE must be 1, 2, 4 or 16");
  end

  localparam logic [4:0] STEP = 5'(BYTES_PER_CYCLE);

  // Handshake: a matrix moves on any rising edge where valid and ready are
  // both high; valid never depends on ready, and a raised valid is held
  // together with its data until the transfer edge.
  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  state_t     mat_q, mat_d;
  logic       inv_q, inv_d;
  logic       in_ready_q, in_ready_d;
  logic       out_valid_q, out_valid_d;
  logic [4:0] cnt_next;

  logic [BYTES_PER_CYCLE-1:0][3:0] lane_idx;
  logic [BYTES_PER_CYCLE-1:0][7:0] sb_in;
  logic [BYTES_PER_CYCLE-1:0][7:0] sb_out;

  // Byte k lives at [3 - k/4][3 - k%4], i.e. the bitwise complement of k's fields.
  always_comb begin
    lane_idx = '0;
    sb_in    = '0;
    for (int i = 0; i < BYTES_PER_CYCLE; i++) begin
      lane_idx[i] = cnt_q + 4'(i);
      sb_in[i]    = mat_q[~lane_idx[i][3:2]][~lane_idx[i][1:0]];
    end
  end

  for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_lane
    sbox u_sbox (
      .in_byte  (sb_in[g]),
      .inverse  (inv_q),
      .out_byte (sb_out[g])
    );
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mat_d    = mat_q;
    inv_d    = inv_q;
    cnt_next = {1'b0, cnt_q} + STEP;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          mat_d   = confusion_in;
          inv_d   = inverse;
          cnt_d   = '0;
          state_d = SUB;
        end
      end
      SUB: begin
        for (int i = 0; i < BYTES_PER_CYCLE; i++) begin
          mat_d[~lane_idx[i][3:2]][~lane_idx[i][1:0]] = sb_out[i];
        end
        cnt_d = cnt_next[3:0];
        if (cnt_next[4]) state_d = HOLD;
      end
      HOLD: begin
        if (out_valid_q && out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // out_valid is registered, so it rises on the first edge spent in HOLD.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_q == HOLD) && (state_d == HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mat_q       <= '0;
      inv_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mat_q       <= mat_d;
      inv_q       <= inv_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign confusion_out = mat_q;
  assign dbg_state     = state_q;

endmodule
